// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment word decoder: active-low glyph patterns and FSM states.
package seg_pkg;

    localparam logic [6:0] GLYPH_0 = 7'b1000000;
    localparam logic [6:0] GLYPH_1 = 7'b1111001;
    localparam logic [6:0] GLYPH_2 = 7'b0100100;
    localparam logic [6:0] GLYPH_3 = 7'b0110000;
    localparam logic [6:0] GLYPH_4 = 7'b0011001;
    localparam logic [6:0] GLYPH_5 = 7'b0010010;
    localparam logic [6:0] GLYPH_6 = 7'b0000010;
    localparam logic [6:0] GLYPH_7 = 7'b1111000;
    localparam logic [6:0] GLYPH_8 = 7'b0000000;
    localparam logic [6:0] GLYPH_9 = 7'b0010000;
    localparam logic [6:0] GLYPH_A = 7'b0001000;
    localparam logic [6:0] GLYPH_B = 7'b0000011;
    localparam logic [6:0] GLYPH_C = 7'b1000110;
    localparam logic [6:0] GLYPH_D = 7'b0100001;
    localparam logic [6:0] GLYPH_E = 7'b0000110;
    localparam logic [6:0] GLYPH_F = 7'b0001110;

    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    // Alternate renderings some displays use for 7 (extra f segment) and 9 (no d segment).
    localparam logic [6:0] GLYPH_ALT_7 = 7'b1011000;
    localparam logic [6:0] GLYPH_ALT_9 = 7'b0011000;

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

endpackage

// File: rtl/seg_word_decoder_if.sv
// Input pattern stream and output word handshake of the seven-segment word decoder.
interface seg_word_decoder_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic [6:0]              seg_in;
    logic                    in_valid;
    logic                    in_ready;
    logic [4*NUM_DIGITS-1:0] word_out;
    logic                    out_valid;
    logic                    out_ready;
    logic                    err;

    modport master (
        output seg_in, in_valid, out_ready,
        input  in_ready, word_out, out_valid, err
    );

    modport slave (
        input  seg_in, in_valid, out_ready,
        output in_ready, word_out, out_valid, err
    );
endinterface

// File: rtl/seg7_to_hex.sv
// Combinational lookup of one active-low segment pattern to a hex nibble.
// Build option SEG_ALT_GLYPH_EN also accepts the alternate 7 and 9 renderings.
module seg7_to_hex
    import seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic       hit,
    output logic       blank,
    output logic [3:0] nibble
);

    always_comb begin
        hit    = 1'b1;
        blank  = 1'b0;
        nibble = 4'h0;
        case (seg)
            GLYPH_0:     nibble = 4'h0;
            GLYPH_1:     nibble = 4'h1;
            GLYPH_2:     nibble = 4'h2;
            GLYPH_3:     nibble = 4'h3;
            GLYPH_4:     nibble = 4'h4;
            GLYPH_5:     nibble = 4'h5;
            GLYPH_6:     nibble = 4'h6;
            GLYPH_7:     nibble = 4'h7;
            GLYPH_8:     nibble = 4'h8;
            GLYPH_9:     nibble = 4'h9;
            GLYPH_A:     nibble = 4'hA;
            GLYPH_B:     nibble = 4'hB;
            GLYPH_C:     nibble = 4'hC;
            GLYPH_D:     nibble = 4'hD;
            GLYPH_E:     nibble = 4'hE;
            GLYPH_F:     nibble = 4'hF;
`ifdef SEG_ALT_GLYPH_EN
            GLYPH_ALT_7: nibble = 4'h7;
            GLYPH_ALT_9: nibble = 4'h9;
`endif
            GLYPH_BLANK: begin
                hit   = 1'b0;
                blank = 1'b1;
            end
            default:     hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_word_decoder.sv
// Assembles NUM_DIGITS decoded seven-segment digits into a hex word, first digit in the top nibble.
// Build option SEG_ALT_GLYPH_EN (see seg7_to_hex) widens the accepted glyph set.
module seg_word_decoder
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4
) (
    input  logic              clk,
    input  logic              reset,
    seg_word_decoder_if.slave bus
);

    localparam int unsigned W  = 4 * NUM_DIGITS;
    localparam int unsigned CW = $clog2(NUM_DIGITS + 1);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    work;
    logic [W-1:0]    word_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic            err_q;

    logic            hit;
    logic            blank;
    logic [3:0]      nibble;
    logic            accept_c;
    logic [W-1:0]    shifted_c;

    seg7_to_hex u_seg7_to_hex (
        .seg    (bus.seg_in),
        .hit    (hit),
        .blank  (blank),
        .nibble (nibble)
    );

    assign accept_c  = bus.in_valid && in_ready_q;
    // Truncating the concatenation drops the oldest nibble and works for any NUM_DIGITS.
    assign shifted_c = W'({work, nibble});

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= COLLECT;
            cnt         <= '0;
            work        <= '0;
            word_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                COLLECT: begin
                    if (accept_c) begin
                        if (hit) begin
                            if (cnt == CW'(NUM_DIGITS - 1)) begin
                                word_q      <= shifted_c;
                                work        <= '0;
                                cnt         <= '0;
                                state       <= FULL;
                                in_ready_q  <= 1'b0;
                                out_valid_q <= 1'b1;
                            end else begin
                                work <= shifted_c;
                                cnt  <= cnt + CW'(1);
                            end
                        end else if (!blank) begin
                            err_q <= 1'b1;
                            work  <= '0;
                            cnt   <= '0;
                        end
                    end
                end
                FULL: begin
                    if (out_valid_q && bus.out_ready) begin
                        state       <= COLLECT;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.word_out  = word_q;
    assign bus.err       = err_q;

endmodule
